// File: rtl/sobel_read_sequencer.sv
// 3x3 window read sequencer for the Sobel engine, one Avalon-MM read in flight.
// Optional: define SEQ_STALL_COUNT_EN to add the stall_cycles waitrequest counter.
module sobel_read_sequencer #(
  parameter int unsigned IMG_WIDTH     = 640,
  parameter int unsigned IMG_HEIGHT    = 480,
  parameter logic [31:0] BASE_ADDR     = 32'h0,
  parameter int unsigned BYTES_PER_PIX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [31:0] avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  input  logic        avm_readdatavalid,
  output logic [31:0] pix_data,
  output logic        pix_valid,
  output logic        pix_full_load,
  output logic        window_ready,
  input  logic        sobel_ack,
  output logic [8:0]  win_row,
  output logic [9:0]  win_col
`ifdef SEQ_STALL_COUNT_EN
  ,
  output logic [31:0] stall_cycles
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_DATA,
    S_WINDOW_READY,
    S_DONE
  } state_e;

  localparam logic [8:0] LAST_ROW = 9'(IMG_HEIGHT - 3);
  localparam logic [9:0] LAST_COL = 10'(IMG_WIDTH - 3);

  state_e      state_q, state_d;
  logic [8:0]  r_q, r_d;
  logic [9:0]  c_q, c_d;
  logic [1:0]  j_q, j_d;
  logic [1:0]  k_q, k_d;
  logic [31:0] pix_data_q, pix_data_d;
  logic        pix_valid_q, pix_valid_d;
  logic        pix_full_q, pix_full_d;

  logic [31:0] pix_row, pix_col, pix_addr;

  // Pixel (r+k, c+j) of the current window; j walks columns, k walks rows.
  assign pix_row  = 32'(r_q) + 32'(k_q);
  assign pix_col  = 32'(c_q) + 32'(j_q);
  assign pix_addr = BASE_ADDR + (pix_row * IMG_WIDTH + pix_col) * BYTES_PER_PIX;

  always_comb begin
    // NOTE: every *_d gets its hold value first, so no path leaves it unassigned and no latch is inferred.
    state_d     = state_q;
    r_d         = r_q;
    c_d         = c_q;
    j_d         = j_q;
    k_d         = k_q;
    pix_data_d  = pix_data_q;
    pix_valid_d = 1'b0;
    pix_full_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_ISSUE;
          r_d     = '0;
          c_d     = '0;
          j_d     = '0;
          k_d     = '0;
        end
      end
      S_ISSUE: begin
        if (!avm_waitrequest) state_d = S_WAIT_DATA;
      end
      S_WAIT_DATA: begin
        if (avm_readdatavalid) begin
          pix_data_d  = avm_readdata;
          pix_valid_d = 1'b1;
          pix_full_d  = (c_q == '0);
          // A 3-pixel load starts at j=2, so k wrapping there also ends the load.
          if (k_q != 2'd2) begin
            k_d     = k_q + 2'd1;
            state_d = S_ISSUE;
          end else if (j_q != 2'd2) begin
            k_d     = '0;
            j_d     = j_q + 2'd1;
            state_d = S_ISSUE;
          end else begin
            k_d     = '0;
            state_d = S_WINDOW_READY;
          end
        end
      end
      S_WINDOW_READY: begin
        if (sobel_ack) begin
          if (r_q == LAST_ROW && c_q == LAST_COL) begin
            state_d = S_DONE;
          end else begin
            state_d = S_ISSUE;
            k_d     = '0;
            if (c_q == LAST_COL) begin
              c_d = '0;
              r_d = r_q + 9'd1;
              j_d = '0;
            end else begin
              c_d = c_q + 10'd1;
              j_d = 2'd2;
            end
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments make every flop sample pre-edge values regardless of statement order.
    if (rst) begin
      state_q     <= S_IDLE;
      r_q         <= '0;
      c_q         <= '0;
      j_q         <= '0;
      k_q         <= '0;
      pix_data_q  <= '0;
      pix_valid_q <= 1'b0;
      pix_full_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      r_q         <= r_d;
      c_q         <= c_d;
      j_q         <= j_d;
      k_q         <= k_d;
      pix_data_q  <= pix_data_d;
      pix_valid_q <= pix_valid_d;
      pix_full_q  <= pix_full_d;
    end
  end

  assign busy          = (state_q != S_IDLE);
  assign done          = (state_q == S_DONE);
  assign avm_read      = (state_q == S_ISSUE);
  assign avm_address   = avm_read ? pix_addr : '0;
  assign window_ready  = (state_q == S_WINDOW_READY);
  assign pix_data      = pix_data_q;
  assign pix_valid     = pix_valid_q;
  assign pix_full_load = pix_full_q;
  assign win_row       = r_q;
  assign win_col       = c_q;

`ifdef SEQ_STALL_COUNT_EN
  logic [31:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (state_q == S_IDLE && start) begin
      stall_d = '0;
    end else if (avm_read && avm_waitrequest && stall_q != '1) begin
      stall_d = stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) stall_q <= '0;
    else     stall_q <= stall_d;
  end

  assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_sobel_read_sequencer.sv
// Randomized self-checking bench for sobel_read_sequencer: three instances
// (640x480, 4x3, 4x4) checked against a nested-loop window/pixel model.
module tb_sobel_read_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        waitreq = 1'b0;
  logic        rdv = 1'b0;
  logic        ack = 1'b0;
  logic [31:0] rdata = '0;
  logic [1:0]  sel = 2'd0;

  logic [2:0]       busy_o, done_o, read_o, pv_o, pfl_o, wr_o;
  logic [2:0][31:0] addr_o, pd_o;
  logic [2:0][8:0]  row_o;
  logic [2:0][9:0]  col_o;
`ifdef SEQ_STALL_COUNT_EN
  logic [2:0][31:0] stall_o;
`endif

  for (genvar g = 0; g < 3; g++) begin : g_dut
    sobel_read_sequencer #(
      .IMG_WIDTH    (g == 0 ? 640 : 4),
      .IMG_HEIGHT   (g == 0 ? 480 : (g == 1 ? 3 : 4)),
      .BASE_ADDR    (32'h0),
      .BYTES_PER_PIX(4)
    ) u_dut (
      .clk              (clk),
      .rst              (rst),
      .start            (start && (sel == 2'(g))),
      .busy             (busy_o[g]),
      .done             (done_o[g]),
      .avm_address      (addr_o[g]),
      .avm_read         (read_o[g]),
      .avm_waitrequest  (waitreq),
      .avm_readdata     (rdata),
      .avm_readdatavalid(rdv),
      .pix_data         (pd_o[g]),
      .pix_valid        (pv_o[g]),
      .pix_full_load    (pfl_o[g]),
      .window_ready     (wr_o[g]),
      .sobel_ack        (ack),
      .win_row          (row_o[g]),
      .win_col          (col_o[g])
`ifdef SEQ_STALL_COUNT_EN
      ,
      .stall_cycles     (stall_o[g])
`endif
    );
  end

  // Outputs of the instance currently under test.
  logic        m_busy, m_done, m_read, m_pv, m_pfl, m_wr;
  logic [31:0] m_addr, m_pd;
  logic [8:0]  m_row;
  logic [9:0]  m_col;
  always_comb begin
    m_busy = busy_o[sel];
    m_done = done_o[sel];
    m_read = read_o[sel];
    m_pv   = pv_o[sel];
    m_pfl  = pfl_o[sel];
    m_wr   = wr_o[sel];
    m_addr = addr_o[sel];
    m_pd   = pd_o[sel];
    m_row  = row_o[sel];
    m_col  = col_o[sel];
  end

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] addr;
    bit          full;
    int          r;
    int          c;
  } rd_t;
  typedef struct {
    int r;
    int c;
    int last_pix;
  } win_t;

  rd_t         exp_q[$];
  win_t        win_q[$];
  logic [31:0] obs_addr[$];
  logic [31:0] salt;
  int          first_req_cycles;

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ salt;
  endfunction

  // Expected read stream: windows row by row, full 3x3 column-major load at
  // c=0, only the new right-hand column otherwise.
  function automatic void build_model(input int w, input int h, input int max_win);
    rd_t  e;
    win_t wi;
    exp_q.delete();
    win_q.delete();
    for (int r = 0; r <= h - 3; r++) begin
      for (int c = 0; c <= w - 3; c++) begin
        if (max_win > 0 && win_q.size() >= max_win) return;
        for (int j = (c == 0) ? 0 : 2; j < 3; j++) begin
          for (int k = 0; k < 3; k++) begin
            e.addr = 32'(((r + k) * w + (c + j)) * 4);
            e.full = (c == 0);
            e.r    = r;
            e.c    = c;
            exp_q.push_back(e);
          end
        end
        wi.r        = r;
        wi.c        = c;
        wi.last_pix = exp_q.size();
        win_q.push_back(wi);
      end
    end
  endfunction

  function automatic bit outs_idle();
    return !m_busy && !m_done && !m_read && !m_pv && !m_pfl && !m_wr &&
           m_addr == '0 && m_pd == '0 && m_row == '0 && m_col == '0;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; start = 1'b1; ack = 1'b0; rdv = 1'b0; waitreq = 1'b0;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
  endtask

  // Starts a frame on instance dut and plays the Avalon slave and Sobel core.
  // Stops after stop_pix pixels (0 = run to done).
  task automatic run_seq(input logic [1:0] dut, input int w, input int h,
                         input int max_win, input int stop_pix, input int first_stall,
                         input int stall_pct, input int lat_max, input int ack_pct,
                         input bit zero_chk);
    int          rd_idx, pix_idx, win_idx, stalls, lat, budget, req_start, forced;
    bit          pending, in_req, done_seen, finished;
    logic [31:0] pend_data;
    build_model(w, h, max_win);
    obs_addr.delete();
    sel = dut;
    salt = $urandom;
    rd_idx = 0; pix_idx = 0; win_idx = 0; stalls = 0; lat = 0; req_start = 0;
    forced = first_stall; pending = 0; in_req = 0; done_seen = 0; finished = 0;
    pend_data = '0; first_req_cycles = 0; budget = 20000;
    @(negedge clk);
    start = 1'b1;
    while (!finished) begin
      @(negedge clk);
      if (m_pv) begin
        n_checks++;
        if (pix_idx >= exp_q.size()) begin
          n_fail++;
          $display("FAIL pix_extra: got pixel %0d, want only %0d", pix_idx, exp_q.size());
        end else begin
          if (m_pd !== mem_val(exp_q[pix_idx].addr) || m_pfl !== exp_q[pix_idx].full) begin
            n_fail++;
            $display("FAIL pix_data: idx=%0d got data=%h full=%b, want data=%h full=%b",
                     pix_idx, m_pd, m_pfl, mem_val(exp_q[pix_idx].addr), exp_q[pix_idx].full);
          end
          if (zero_chk) begin
            n_checks++;
            if (cyc - req_start != 2) begin
              n_fail++;
              $display("FAIL pix_latency: idx=%0d got %0d cycles, want 2", pix_idx, cyc - req_start);
            end
          end
        end
        pix_idx++;
        if (stop_pix > 0 && pix_idx == stop_pix) finished = 1;
      end
      if (!finished && m_read) begin
        if (!in_req) begin
          in_req = 1; req_start = cyc; obs_addr.push_back(m_addr);
        end
        if (rd_idx == 0) first_req_cycles++;
        n_checks++;
        if (rd_idx >= exp_q.size()) begin
          n_fail++;
          $display("FAIL read_extra: got read %0d addr=%h, want only %0d", rd_idx, m_addr, exp_q.size());
        end else if (m_addr !== exp_q[rd_idx].addr || m_row !== 9'(exp_q[rd_idx].r) ||
                     m_col !== 10'(exp_q[rd_idx].c)) begin
          n_fail++;
          $display("FAIL read_addr: idx=%0d got addr=%h row=%0d col=%0d, want addr=%h row=%0d col=%0d",
                   rd_idx, m_addr, m_row, m_col, exp_q[rd_idx].addr, exp_q[rd_idx].r, exp_q[rd_idx].c);
        end
      end
      if (!finished && m_wr) begin
        n_checks++;
        if (win_idx >= win_q.size()) begin
          n_fail++;
          $display("FAIL window_extra: got window %0d, want only %0d", win_idx, win_q.size());
        end else if (m_row !== 9'(win_q[win_idx].r) || m_col !== 10'(win_q[win_idx].c) ||
                     pix_idx != win_q[win_idx].last_pix) begin
          n_fail++;
          $display("FAIL window: got row=%0d col=%0d pixels=%0d, want row=%0d col=%0d pixels=%0d",
                   m_row, m_col, pix_idx, win_q[win_idx].r, win_q[win_idx].c, win_q[win_idx].last_pix);
        end
      end
      if (!finished) begin
        if (done_seen) begin
          n_checks++;
          if (m_busy !== 1'b0 || m_done !== 1'b0 || win_idx != win_q.size() || pix_idx != exp_q.size()) begin
            n_fail++;
            $display("FAIL frame_end: got busy=%b done=%b windows=%0d pixels=%0d, want 0 0 %0d %0d",
                     m_busy, m_done, win_idx, pix_idx, win_q.size(), exp_q.size());
          end
          finished = 1;
        end else if (m_done) begin
          done_seen = 1;
        end
      end
      budget--;
      if (!finished && budget == 0) begin
        n_checks++; n_fail++;
        $display("FAIL timeout: got no frame end after 20000 cycles, want completion");
        finished = 1;
      end
      if (!finished) begin
        rdv     = 1'b0;
        rdata   = $urandom;
        ack     = 1'b0;
        waitreq = 1'($urandom_range(0, 1));
        start   = m_busy ? 1'($urandom_range(0, 1)) : 1'b0;
        if (pending) begin
          if (lat == 0) begin
            rdv = 1'b1; rdata = pend_data; pending = 0;
          end else begin
            lat--;
          end
        end
        if (m_read) begin
          rdv = ($urandom_range(0, 3) == 0);
          if (forced > 0) begin
            waitreq = 1'b1; forced--;
          end else begin
            waitreq = ($urandom_range(0, 99) < stall_pct);
          end
          if (waitreq) begin
            stalls++;
          end else begin
            pending = 1; lat = $urandom_range(0, lat_max);
            pend_data = mem_val(m_addr); rd_idx++; in_req = 0;
          end
        end
        if (m_wr) begin
          ack = ($urandom_range(0, 99) < ack_pct);
          if (ack) win_idx++;
        end else begin
          ack = ($urandom_range(0, 3) == 0);
        end
      end
    end
`ifdef SEQ_STALL_COUNT_EN
    n_checks++;
    if (stall_o[sel] !== 32'(stalls)) begin
      n_fail++;
      $display("FAIL stall_cycles: got %0d, want %0d", stall_o[sel], stalls);
    end
`endif
    start = 1'b0; rdv = 1'b0; ack = 1'b0; waitreq = 1'b0;
  endtask

  task automatic test_reset();
    for (int g = 0; g < 3; g++) begin
      sel = 2'(g);
      @(negedge clk);
      rst = 1'b1; start = 1'b1; rdv = 1'b1; ack = 1'b1;
      @(negedge clk);
      n_checks++;
      if (!outs_idle()) begin
        n_fail++;
        $display("FAIL reset_outs: dut=%0d got busy=%b read=%b addr=%h pv=%b, want all 0", g, m_busy, m_read, m_addr, m_pv);
      end
      rst = 1'b0; start = 1'b0; rdv = 1'b0; ack = 1'b0;
      @(negedge clk);
      n_checks++;
      if (!outs_idle()) begin
        n_fail++;
        $display("FAIL reset_idle: dut=%0d got busy=%b read=%b, want all 0", g, m_busy, m_read);
      end
    end
  endtask

  task automatic test_first_windows();
    logic [31:0] want [12];
    want = '{32'h0, 32'hA00, 32'h1400, 32'h4, 32'hA04, 32'h1404,
             32'h8, 32'hA08, 32'h1408, 32'hC, 32'hA0C, 32'h140C};
    do_reset();
    run_seq(2'd0, 640, 480, 2, 12, 0, 0, 0, 100, 1'b1);
    n_checks++;
    if (obs_addr.size() != 12) begin
      n_fail++;
      $display("FAIL first_count: got %0d reads, want 12", obs_addr.size());
    end else begin
      for (int i = 0; i < 12; i++) begin
        n_checks++;
        if (obs_addr[i] !== want[i]) begin
          n_fail++;
          $display("FAIL first_addr: idx=%0d got %h, want %h", i, obs_addr[i], want[i]);
        end
      end
    end
  endtask

  task automatic test_small_frame();
    do_reset();
    run_seq(2'd1, 4, 3, 0, 0, 0, 0, 0, 100, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++;
      if (m_done !== 1'b0 || m_busy !== 1'b0) begin
        n_fail++;
        $display("FAIL after_done: got done=%b busy=%b, want 0 0", m_done, m_busy);
      end
    end
  endtask

  task automatic test_row_wrap();
    run_seq(2'd2, 4, 4, 0, 0, 0, 0, 0, 100, 1'b0);
    n_checks++;
    if (obs_addr.size() < 13 || obs_addr[12] !== 32'h10) begin
      n_fail++;
      $display("FAIL row_wrap: got %0d reads, read 12 addr=%h, want addr 00000010",
               obs_addr.size(), obs_addr.size() > 12 ? obs_addr[12] : 32'hx);
    end
  endtask

  task automatic test_stall();
    do_reset();
    run_seq(2'd0, 640, 480, 1, 1, 5, 0, 0, 100, 1'b0);
    n_checks++;
    if (first_req_cycles != 6) begin
      n_fail++;
      $display("FAIL stall_hold: got read held %0d cycles, want 6", first_req_cycles);
    end
  endtask

  task automatic test_reset_mid_read();
    sel = 2'd0;
    do_reset();
    @(negedge clk);
    start = 1'b1; waitreq = 1'b0;
    @(negedge clk);
    start = 1'b0;
    n_checks++;
    if (m_read !== 1'b1 || m_addr !== 32'h0) begin
      n_fail++;
      $display("FAIL mid_issue: got read=%b addr=%h, want 1 00000000", m_read, m_addr);
    end
    @(negedge clk);
    n_checks++;
    if (m_busy !== 1'b1 || m_read !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_wait: got busy=%b read=%b, want 1 0", m_busy, m_read);
    end
    rst = 1'b1; rdv = 1'b1; rdata = 32'hDEADBEEF;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (!outs_idle()) begin
        n_fail++;
        $display("FAIL mid_reset: cycle=%0d got pv=%b data=%h busy=%b, want all 0", i, m_pv, m_pd, m_busy);
      end
      @(negedge clk);
      rdv = 1'b0;
    end
    run_seq(2'd0, 640, 480, 1, 1, 0, 20, 2, 100, 1'b0);
    n_checks++;
    if (obs_addr.size() < 1 || obs_addr[0] !== 32'h0) begin
      n_fail++;
      $display("FAIL restart_addr: got %0d reads, want first addr 00000000", obs_addr.size());
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) begin
      run_seq(2'(1 + (i % 2)), 4, 3 + (i % 2), 0, 0, $urandom_range(0, 3),
              $urandom_range(0, 50), $urandom_range(0, 3), $urandom_range(20, 100), 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_first_windows();
    test_small_frame();
    test_row_wrap();
    test_stall();
    test_reset_mid_read();
    do_reset();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
